// File: rtl/vga_fb_reader.sv
// Framebuffer scan-out: turns scan positions into framebuffer reads and lines the colour up with delayed timing.
// Optional FB_BORDER_EN macro forces a white one-pixel frame around the active area.
module vga_fb_reader #(
    parameter int H_W         = 800,
    parameter int V_H         = 480,
    parameter int SCALE_SHIFT = 1,
    parameter int RD_LAT      = 2,
    parameter int ADDR_W      = 17
) (
    input  logic              pix_clk,
    input  logic              pix_rstn,
    input  logic [15:0]       sx,
    input  logic [15:0]       sy,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              de_in,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [11:0]       fb_data,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start
);
    localparam int L = 1 + RD_LAT;
    localparam int FB_W = H_W >> SCALE_SHIFT;
    localparam logic [15:0] SY_MASK = 16'((1 << SCALE_SHIFT) - 1);

    logic [ADDR_W-1:0] row_base;
    logic [L-1:0]      hs_dly;
    logic [L-1:0]      vs_dly;
    logic [L-1:0]      de_dly;
    logic [L-1:0]      fs_dly;
    logic              line_end;
    logic              sy_active;
    logic              row_step;
    logic              fs_in;

    assign line_end  = (sx == 16'(H_W));
    assign sy_active = (sy < 16'(V_H));
    // Only the last screen line of each replicated group moves to the next framebuffer row.
    assign row_step  = line_end && ((sy & SY_MASK) == SY_MASK);
    assign fs_in     = de_in && (sx == 16'd0) && (sy == 16'd0);

    always_ff @(posedge pix_clk or negedge pix_rstn) begin
        if (!pix_rstn) begin
            row_base <= '0;
        end else if (!sy_active) begin
            row_base <= '0;
        end else if (row_step) begin
            row_base <= row_base + ADDR_W'(FB_W);
        end
    end

    always_ff @(posedge pix_clk or negedge pix_rstn) begin
        if (!pix_rstn) begin
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
        end else begin
            fb_rd_en <= de_in;
            if (de_in) begin
                fb_addr <= row_base + ADDR_W'(sx >> SCALE_SHIFT);
            end
        end
    end

    always_ff @(posedge pix_clk or negedge pix_rstn) begin
        if (!pix_rstn) begin
            hs_dly <= '1;
            vs_dly <= '1;
            de_dly <= '0;
            fs_dly <= '0;
        end else begin
            hs_dly <= {hs_dly[L-2:0], hsync_in};
            vs_dly <= {vs_dly[L-2:0], vsync_in};
            de_dly <= {de_dly[L-2:0], de_in};
            fs_dly <= {fs_dly[L-2:0], fs_in};
        end
    end

`ifdef FB_BORDER_EN
    logic [L-1:0] edge_dly;
    logic         edge_in;

    assign edge_in = (sx == 16'd0) || (sx == 16'(H_W - 1)) ||
                     (sy == 16'd0) || (sy == 16'(V_H - 1));

    always_ff @(posedge pix_clk or negedge pix_rstn) begin
        if (!pix_rstn) begin
            edge_dly <= '0;
        end else begin
            edge_dly <= {edge_dly[L-2:0], edge_in};
        end
    end
`endif

    assign hsync       = hs_dly[L-1];
    assign vsync       = vs_dly[L-1];
    assign de          = de_dly[L-1];
    assign frame_start = fs_dly[L-1];

    // Read data arrives in the same cycle as the delayed timing, so colour is a plain mux.
    always_comb begin
        r = '0;
        g = '0;
        b = '0;
        if (de) begin
            r = {fb_data[11:8], fb_data[11:8]};
            g = {fb_data[7:4], fb_data[7:4]};
            b = {fb_data[3:0], fb_data[3:0]};
`ifdef FB_BORDER_EN
            if (edge_dly[L-1]) begin
                r = 8'hFF;
                g = 8'hFF;
                b = 8'hFF;
            end
`endif
        end
    end
endmodule

// File: tb/tb_vga_fb_reader.sv
// Randomised bench for vga_fb_reader with a pixel-coordinate reference model and a framebuffer model returning addr[11:0].
// Builds with or without FB_BORDER_EN.
module tb_vga_fb_reader;
    localparam int H_W    = 800;
    localparam int V_H    = 480;
    localparam int SS     = 1;
    localparam int RD_LAT = 2;
    localparam int ADDR_W = 17;
    localparam int L      = 1 + RD_LAT;
    localparam int FB_W   = H_W >> SS;

    logic              pix_clk = 1'b0;
    logic              pix_rstn;
    logic [15:0]       sx, sy;
    logic              hsync_in, vsync_in, de_in;
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_addr;
    logic [11:0]       fb_data;
    logic [7:0]        r, g, b;
    logic              hsync, vsync, de, frame_start;

    vga_fb_reader #(
        .H_W(H_W), .V_H(V_H), .SCALE_SHIFT(SS), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .pix_clk(pix_clk), .pix_rstn(pix_rstn), .sx(sx), .sy(sy),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_data(fb_data),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .de(de),
        .frame_start(frame_start)
    );

    always #5 pix_clk = ~pix_clk;

    // Framebuffer model: two-stage read pipeline, word content is its own low address bits.
    logic [ADDR_W-1:0] p1, p2;
    logic              fb_zero;
    always @(posedge pix_clk) begin
        p1 <= fb_addr;
        p2 <= p1;
    end
    assign fb_data = fb_zero ? 12'h000 : p2[11:0];

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic       known;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t              q[$];
    int                compared   = 0;
    int                mismatched = 0;
    int                nstep      = 0;
    logic              track;
    logic [ADDR_W-1:0] exp_addr;

    function automatic exp_t model(input int x, input int y, input logic h, input logic v, input logic d);
        exp_t e;
        int word;
        logic [11:0] w;
        e.hs = h;
        e.vs = v;
        e.de = d;
        e.fs = d && (x == 0) && (y == 0);
        e.known = track || fb_zero;
        word = (y / (1 << SS)) * FB_W + (x / (1 << SS));
        w = fb_zero ? 12'h000 : 12'(word);
        e.r = d ? {w[11:8], w[11:8]} : 8'h00;
        e.g = d ? {w[7:4], w[7:4]} : 8'h00;
        e.b = d ? {w[3:0], w[3:0]} : 8'h00;
`ifdef FB_BORDER_EN
        if (d && (x == 0 || x == H_W - 1 || y == 0 || y == V_H - 1)) begin
            e.r = 8'hFF;
            e.g = 8'hFF;
            e.b = 8'hFF;
        end
`endif
        return e;
    endfunction

    // Apply one input cycle, then score the outputs against the model queue.
    task automatic step(input int x, input int y, input logic h, input logic v, input logic d);
        exp_t e, o;
        sx = 16'(x);
        sy = 16'(y);
        hsync_in = h;
        vsync_in = v;
        de_in = d;
        e = model(x, y, h, v, d);
        q.push_back(e);
        if (d && track) exp_addr = ADDR_W'((y / (1 << SS)) * FB_W + (x / (1 << SS)));
        @(posedge pix_clk);
        #1;
        nstep++;
        compared++;
        if (fb_rd_en !== d) begin
            mismatched++;
            $display("FAIL rd_en step=%0d x=%0d y=%0d: got %b expected %b", nstep, x, y, fb_rd_en, d);
        end
        if (track) begin
            compared++;
            if (fb_addr !== exp_addr) begin
                mismatched++;
                $display("FAIL fb_addr step=%0d x=%0d y=%0d: got %0d expected %0d", nstep, x, y, fb_addr, exp_addr);
            end
        end
        if (q.size() == L) o = q.pop_front();
        else o = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, known: 1'b1, r: 8'h00, g: 8'h00, b: 8'h00};
        compared++;
        if ({hsync, vsync, de, frame_start} !== {o.hs, o.vs, o.de, o.fs}) begin
            mismatched++;
            $display("FAIL timing step=%0d: got hs/vs/de/fs=%b expected %b", nstep,
                     {hsync, vsync, de, frame_start}, {o.hs, o.vs, o.de, o.fs});
        end
        if (o.known) begin
            compared++;
            if ({r, g, b} !== {o.r, o.g, o.b}) begin
                mismatched++;
                $display("FAIL rgb step=%0d: got %h expected %h", nstep, {r, g, b}, {o.r, o.g, o.b});
            end
        end
    endtask

    task automatic blank(input int y);
        for (int x = H_W; x < H_W + 6; x++)
            step(x, y, !(x == H_W + 2 || x == H_W + 3), !(y == V_H + 1), 1'b0);
    endtask

    task automatic run_line(input int y);
        if (y < V_H) begin
            step(0, y, 1'b1, 1'b1, 1'b1);
            for (int k = 0; k < 6; k++) step(int'($urandom_range(1, H_W - 2)), y, 1'b1, 1'b1, 1'b1);
            step(H_W - 1, y, 1'b1, 1'b1, 1'b1);
        end
        blank(y);
    endtask

    task automatic run_frame();
        for (int y = 0; y < V_H + 3; y++) run_line(y);
    endtask

    task automatic test_reset();
        pix_rstn = 1'b0;
        fb_zero = 1'b0;
        track = 1'b1;
        exp_addr = '0;
        sx = 16'd0;
        sy = 16'd0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        de_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge pix_clk);
            #1;
            compared++;
            if ({hsync, vsync, de, frame_start, fb_rd_en, r, g, b, fb_addr} !==
                {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, {ADDR_W{1'b0}}}) begin
                mismatched++;
                $display("FAIL reset_hold cycle=%0d: got hs=%b vs=%b de=%b fs=%b rd=%b rgb=%h addr=%0d", i,
                         hsync, vsync, de, frame_start, fb_rd_en, {r, g, b}, fb_addr);
            end
        end
        q.delete();
        pix_rstn = 1'b1;
        for (int i = 0; i < 4; i++) step(i, V_H + 2, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_first_lines();
        track = 1'b1;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < H_W; x++) begin
                step(x, y, 1'b1, 1'b1, 1'b1);
                if (x == 0 && y == 0) begin
                    compared++;
                    if ({fb_rd_en, fb_addr} !== {1'b1, {ADDR_W{1'b0}}}) begin
                        mismatched++;
                        $display("FAIL first_read: got rd=%b addr=%0d expected rd=1 addr=0", fb_rd_en, fb_addr);
                    end
                end
                if (x == 2 && y == 0) begin
                    compared++;
                    if ({de, frame_start} !== 2'b11) begin
                        mismatched++;
                        $display("FAIL first_out: got de=%b fs=%b expected de=1 fs=1", de, frame_start);
                    end
                end
                if (x == 3 && y == 0) begin
                    compared++;
                    if (frame_start !== 1'b0) begin
                        mismatched++;
                        $display("FAIL fs_width: got %b expected 0", frame_start);
                    end
                end
                if (x == H_W - 1 && y < 2) begin
                    compared++;
                    if (fb_addr !== ADDR_W'(FB_W - 1)) begin
                        mismatched++;
                        $display("FAIL line_end y=%0d: got %0d expected %0d", y, fb_addr, FB_W - 1);
                    end
                end
                if (x == 0 && y == 2) begin
                    compared++;
                    if (fb_addr !== ADDR_W'(FB_W)) begin
                        mismatched++;
                        $display("FAIL line2_start: got %0d expected %0d", fb_addr, FB_W);
                    end
                end
                if (x == 7 && y == 3) begin
                    compared++;
                    if ({r, g, b} !== 24'h119922) begin
                        mismatched++;
                        $display("FAIL pixel_5_3: got %h expected 119922", {r, g, b});
                    end
                end
            end
            blank(y);
        end
        for (int y = 4; y < V_H - 1; y++) run_line(y);
        step(0, V_H - 1, 1'b1, 1'b1, 1'b1);
        step(int'($urandom_range(1, H_W - 2)), V_H - 1, 1'b1, 1'b1, 1'b1);
        step(H_W - 1, V_H - 1, 1'b1, 1'b1, 1'b1);
        compared++;
        if (fb_addr !== ADDR_W'(95999)) begin
            mismatched++;
            $display("FAIL last_addr: got %0d expected 95999", fb_addr);
        end
        blank(V_H - 1);
        blank(V_H);
        compared++;
        if (dut.row_base !== '0) begin
            mismatched++;
            $display("FAIL vblank_row_base: got %0d expected 0", dut.row_base);
        end
        blank(V_H + 1);
        blank(V_H + 2);
    endtask

    task automatic test_jump();
        int y;
        int x0;
        track = 1'b0;
        for (int k = 0; k < 25; k++) begin
            y = int'($urandom_range(0, V_H + 2));
            x0 = int'($urandom_range(0, H_W + 3));
            for (int x = x0; x < x0 + 5; x++)
                step(x, y, 1'b1, 1'b1, (x < H_W) && (y < V_H));
        end
        blank(V_H);
        blank(V_H + 1);
        track = 1'b1;
        run_frame();
    endtask

    task automatic test_reset_midline();
        track = 1'b0;
        for (int x = 290; x <= 300; x++) step(x, 100, 1'b1, 1'b1, 1'b1);
        #2;
        pix_rstn = 1'b0;
        #1;
        compared++;
        if ({hsync, vsync, de, frame_start, fb_rd_en, r, g, b, fb_addr} !==
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, {ADDR_W{1'b0}}}) begin
            mismatched++;
            $display("FAIL async_reset: got hs=%b vs=%b de=%b fs=%b rd=%b rgb=%h addr=%0d",
                     hsync, vsync, de, frame_start, fb_rd_en, {r, g, b}, fb_addr);
        end
        repeat (3) @(posedge pix_clk);
        #1;
        q.delete();
        exp_addr = '0;
        pix_rstn = 1'b1;
        track = 1'b1;
        run_frame();
    endtask

`ifdef FB_BORDER_EN
    task automatic test_border();
        int px[5] = '{0, H_W - 1, 10, 10, 10};
        int py[5] = '{10, 10, 0, V_H - 1, 10};
        logic [7:0] ev[5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        track = 1'b0;
        fb_zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(px[i], py[i], 1'b1, 1'b1, 1'b1);
            step(H_W + 1, py[i], 1'b1, 1'b1, 1'b0);
            step(H_W + 1, py[i], 1'b1, 1'b1, 1'b0);
            compared++;
            if ({r, g, b} !== {ev[i], ev[i], ev[i]}) begin
                mismatched++;
                $display("FAIL border (%0d,%0d): got %h expected %h", px[i], py[i], {r, g, b}, {ev[i], ev[i], ev[i]});
            end
        end
        fb_zero = 1'b0;
        blank(V_H);
    endtask
`endif

    initial begin
        test_reset();
        test_first_lines();
        test_jump();
        test_reset_midline();
`ifdef FB_BORDER_EN
        test_border();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
